// File: rtl/line_memory_responder_if.sv
// Request/response bundle between the data-cache memory-side master and the line memory.
interface line_memory_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
);
    logic [ADDR_W-1:0] addr_i;
    logic [LINE_W-1:0] data_i;
    logic              enable_i;
    logic              write_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;

    modport master (output addr_i, data_i, enable_i, write_i, input  ack_o, data_o);
    modport slave  (input  addr_i, data_i, enable_i, write_i, output ack_o, data_o);
endinterface

// File: rtl/line_memory_responder.sv
// Fixed-latency line memory for cache refill/write-back traffic.
// Optional protocol checker: define LINE_MEMORY_RESPONDER_CHECK_EN to add proto_err_o.
module line_memory_responder #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    line_memory_responder_if.slave bus
`ifdef LINE_MEMORY_RESPONDER_CHECK_EN
    ,
    output logic proto_err_o
`endif
);
    localparam int unsigned OFS_W = $clog2(LINE_W / 8);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdat_q, wdat_d;
    logic              wr_q, wr_d;
    logic              ack_q, ack_d;
    logic [LINE_W-1:0] rdat_q, rdat_d;

    logic              acc_c;
    logic              acc_wr_c;
    logic [IDX_W-1:0]  acc_idx_c;
    logic [IDX_W-1:0]  in_idx_c;
    logic [LINE_W-1:0] acc_dat_c;

    logic [LINE_W-1:0] mem [DEPTH];

    // Offset bits below the line and address bits above the array alias away.
    assign in_idx_c = bus.addr_i[OFS_W +: IDX_W];
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr_i[ADDR_W-1:OFS_W+IDX_W], bus.addr_i[OFS_W-1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdat_d    = wdat_q;
        wr_d      = wr_q;
        rdat_d    = rdat_q;
        acc_c     = 1'b0;
        acc_idx_c = idx_q;
        acc_dat_c = wdat_q;
        acc_wr_c  = wr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.enable_i) begin
                    idx_d  = in_idx_c;
                    wdat_d = bus.data_i;
                    wr_d   = bus.write_i;
                    cnt_d  = CNT_W'(LATENCY - 1);
                    // Single-cycle latency performs the access on the accepting edge.
                    if (LATENCY == 1) begin
                        acc_c     = 1'b1;
                        acc_idx_c = in_idx_c;
                        acc_dat_c = bus.data_i;
                        acc_wr_c  = bus.write_i;
                        state_d   = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    acc_c   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ack_d = (state_d == ST_ACK);
        if (acc_c && !acc_wr_c) begin
            rdat_d = mem[acc_idx_c];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdat_q  <= '0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (acc_c && acc_wr_c) begin
            mem[acc_idx_c] <= acc_dat_c;
        end
    end

    assign bus.ack_o  = ack_q;
    assign bus.data_o = rdat_q;

`ifdef LINE_MEMORY_RESPONDER_CHECK_EN
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              proto_err_q, proto_err_d;
    logic              err_c;

    always_comb begin
        addr_d = addr_q;
        if (state_q == ST_IDLE && bus.enable_i) begin
            addr_d = bus.addr_i;
        end
        err_c = (state_q == ST_WAIT) &&
                (!bus.enable_i || (bus.addr_i != addr_q) || (bus.write_i != wr_q) ||
                 (wr_q && (bus.data_i != wdat_q)));
        proto_err_d = proto_err_q | err_c;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            proto_err_q <= proto_err_d;
            if (err_c && !proto_err_q) begin
                $display("line_memory_responder: warning, request changed or dropped while waiting");
            end
        end
    end

    assign proto_err_o = proto_err_q;
`endif
endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: reset, latency, write/read, aliasing, reset abort.
module tb_line_memory_responder;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LINE_W  = 256;
    localparam int unsigned DEPTH   = 512;
    localparam int unsigned LATENCY = 10;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    line_memory_responder_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

`ifdef LINE_MEMORY_RESPONDER_CHECK_EN
    logic proto_err;
`endif

    line_memory_responder #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
`ifdef LINE_MEMORY_RESPONDER_CHECK_EN
        ,
        .proto_err_o(proto_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request, measure accept-to-ack latency, check read data in the ack cycle.
    task automatic do_req(input string tag, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                          input logic w, input logic hold, input logic [LINE_W-1:0] exp_data);
        int lat;
        lat = 0;
        bus.addr_i   = a;
        bus.data_i   = d;
        bus.write_i  = w;
        bus.enable_i = 1'b1;
        for (int c = 1; c <= int'(LATENCY) + 5; c++) begin
            tick();
            if (bus.ack_o === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_lat"}, LINE_W'(lat), LINE_W'(LATENCY));
        chk({tag, "_data"}, bus.data_o, exp_data);
        bus.enable_i = hold;
        tick();
        chk({tag, "_pulse"}, LINE_W'(bus.ack_o), LINE_W'(0));
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        bus.addr_i   = '0;
        bus.data_i   = '0;
        bus.write_i  = 1'b0;
        bus.enable_i = 1'b0;

        tick();
        tick();
        chk("rst_ack", LINE_W'(bus.ack_o), LINE_W'(0));
        chk("rst_data", bus.data_o, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_ack", LINE_W'(bus.ack_o), LINE_W'(0));
        end
        chk("idle_data", bus.data_o, '0);

        dut.mem[0] = 256'h5;
        dut.mem[2] = 256'hAAAA;
        do_req("rd0", 32'h0000_0000, '0, 1'b0, 1'b0, 256'h5);

        // Write keeps data_o at the previous read value; read follows back-to-back.
        do_req("wr33", 32'h0000_0420, 256'hDEAD_BEEF, 1'b1, 1'b1, 256'h5);
        do_req("rd33", 32'h0000_0420, '0, 1'b0, 1'b0, 256'hDEAD_BEEF);
        chk("mem33", dut.mem[33], 256'hDEAD_BEEF);

        do_req("alias", 32'h0000_401F, '0, 1'b0, 1'b0, 256'h5);

        // Reset four cycles after accepting a write aborts it.
        bus.addr_i   = 32'h0000_0040;
        bus.data_i   = 256'h1;
        bus.write_i  = 1'b1;
        bus.enable_i = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        rst_n        = 1'b0;
        bus.enable_i = 1'b0;
        #1;
        chk("abort_state", LINE_W'(dut.state_q), LINE_W'(0));
        chk("abort_data", bus.data_o, '0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("abort_ack", LINE_W'(bus.ack_o), LINE_W'(0));
        end
        chk("abort_mem2", dut.mem[2], 256'hAAAA);

        do_req("rd33_post", 32'h0000_0420, '0, 1'b0, 1'b0, 256'hDEAD_BEEF);

`ifdef LINE_MEMORY_RESPONDER_CHECK_EN
        chk("perr_init", LINE_W'(proto_err), LINE_W'(0));
        bus.addr_i   = 32'h0;
        bus.write_i  = 1'b0;
        bus.enable_i = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        chk("perr_before", LINE_W'(proto_err), LINE_W'(0));
        bus.enable_i = 1'b0;
        tick();
        chk("perr_set", LINE_W'(proto_err), LINE_W'(1));
        for (int i = 0; i < 12; i++) tick();
        chk("perr_sticky", LINE_W'(proto_err), LINE_W'(1));
        rst_n = 1'b0;
        #1;
        chk("perr_rst", LINE_W'(proto_err), LINE_W'(0));
        tick();
        rst_n = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
